// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - command/result bundle between an add requester and the serial adder
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    modport master (
        output start, a_in, b_in, cin_in,
        input  busy, done, sum_out, cout_out
    );

    modport slave (
        input  start, a_in, b_in, cin_in,
        output busy, done, sum_out, cout_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer driving one shared fulladder cell
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] s_sr;
    logic [WIDTH-1:0] s_full;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == LAST_CNT);
    // Partial sum plus the bit being produced this cycle, MSB-aligned.
    assign s_full   = {fa_sum, s_sr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_in;
            carry <= bus.cin_in;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_full[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            // Result registers move only here so the previous answer stays readable mid-run.
            if (last_bit) begin
                sum_q  <= s_full;
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.sum_out  = sum_q;
    assign bus.cout_out = cout_q;
endmodule
